fan_speed_ctrl: RTL and testbench

FAN_SPEED_CTRL -- requirements
Module: fan_speed_ctrl

---
 rtl/fan_ctrl_pkg.sv | 21 ++
 rtl/fan_pwm_gen.sv | 43 ++++
 rtl/fan_speed_ctrl.sv | 99 +++++++++
 tb/tb_fan_speed_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the fan speed controller: FSM state encoding,
// default sizing constants and the level-to-duty conversion.
package fan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_LOCK = 2'd2,
      ST_OVT  = 2'd3
   } fan_state_t;

   localparam int DEF_LEVELS   = 4;
   localparam int DEF_DWELL    = 3;
   localparam int DEF_PWM_BITS = 4;

   // floor(lvl * 2^pwm_bits / (levels-1)); top level maps to a full period
   function automatic int duty_of(int lvl, int levels, int pwm_bits);
      return (lvl << pwm_bits) / (levels - 1);
   endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Fan PWM generator: free-running period counter, duty latched at the
// period wrap so level changes only take effect on a period boundary.
module fan_pwm_gen
   import fan_ctrl_pkg::*;
#(
   parameter int LEVELS   = DEF_LEVELS,
   parameter int PWM_BITS = DEF_PWM_BITS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [$clog2(LEVELS)-1:0] level,
   output logic                      pwm
);

   localparam int DUTY_W = PWM_BITS + 1;
   localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

   logic [PWM_BITS-1:0] cnt, cnt_nxt;
   logic [DUTY_W-1:0]   duty, duty_nxt;

   // next counter value and duty (reloaded only on the last count of a period)
   always_comb begin
      cnt_nxt  = cnt + 1'b1;
      duty_nxt = duty;
      if (cnt == CNT_MAX) begin
         duty_nxt = DUTY_W'(duty_of(int'(level), LEVELS, PWM_BITS));
      end
   end

   // counter, duty latch and registered compare; pwm always reflects cnt < duty
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         duty <= '0;
         pwm  <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         duty <= duty_nxt;
         pwm  <= ({1'b0, cnt_nxt} < duty_nxt);
      end
   end

endmodule

// File: rtl/fan_speed_ctrl.sv
// Fan speed controller: up/down stepping with a dwell lockout after each
// level change, overtemp forcing to full speed, PWM fan drive.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_STOP | level 0, no lockout
//   ST_RUN  | level > 0, no lockout, steps accepted
//   ST_LOCK | dwell counter nonzero, single steps dropped
//   ST_OVT  | overtemp asserted, level forced to maximum
module fan_speed_ctrl
   import fan_ctrl_pkg::*;
#(
   parameter int LEVELS   = DEF_LEVELS,
   parameter int DWELL    = DEF_DWELL,
   parameter int PWM_BITS = DEF_PWM_BITS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      up,
   input  logic                      down,
   input  logic                      overtemp,
   output logic [$clog2(LEVELS)-1:0] speed,
   output logic                      pwm,
   output logic                      busy
);

   localparam int LW  = $clog2(LEVELS);
   localparam int DWW = $clog2(DWELL + 1);
   localparam logic [LW-1:0]  LVL_MAX  = LW'(LEVELS - 1);
   localparam logic [DWW-1:0] DWELL_LD = DWW'(DWELL);

   fan_state_t     state, state_nxt;
   logic [LW-1:0]  level, level_nxt;
   logic [DWW-1:0] dwell, dwell_nxt;

   // next state / level / dwell; priority overtemp > up&down > lockout > step
   always_comb begin
      state_nxt = state;
      level_nxt = level;
      dwell_nxt = dwell;
      if (overtemp) begin
         state_nxt = ST_OVT;
         level_nxt = LVL_MAX;
         dwell_nxt = '0;
      end else if (up && down) begin
         state_nxt = ST_STOP;
         level_nxt = '0;
         dwell_nxt = '0;
      end else if (state == ST_OVT) begin
         // leaving overtemp holds full speed for a dwell before stepping
         state_nxt = ST_LOCK;
         dwell_nxt = DWELL_LD;
      end else if (dwell != '0) begin
         dwell_nxt = dwell - 1'b1;
         if (dwell != DWW'(1)) begin
            state_nxt = ST_LOCK;
         end else begin
            state_nxt = (level == '0) ? ST_STOP : ST_RUN;
         end
      end else if (up && (level != LVL_MAX)) begin
         state_nxt = ST_LOCK;
         level_nxt = level + 1'b1;
         dwell_nxt = DWELL_LD;
      end else if (down && (level != '0)) begin
         state_nxt = ST_LOCK;
         level_nxt = level - 1'b1;
         dwell_nxt = DWELL_LD;
      end else begin
         state_nxt = (level == '0) ? ST_STOP : ST_RUN;
      end
   end

   // FSM, level and dwell registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_STOP;
         level <= '0;
         dwell <= '0;
      end else begin
         state <= state_nxt;
         level <= level_nxt;
         dwell <= dwell_nxt;
      end
   end

   assign speed = level;
   assign busy  = (dwell != '0);

   fan_pwm_gen #(
      .LEVELS   (LEVELS),
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clk   (clk),
      .reset (reset),
      .level (level),
      .pwm   (pwm)
   );

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Self-checking bench for fan_speed_ctrl (LEVELS=4, DWELL=3, PWM_BITS=4).
module tb_fan_speed_ctrl;

   localparam int LEVELS   = 4;
   localparam int DWELL    = 3;
   localparam int PWM_BITS = 4;
   localparam int PERIOD   = 1 << PWM_BITS;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic up = 1'b0;
   logic down = 1'b0;
   logic overtemp = 1'b0;
   logic [$clog2(LEVELS)-1:0] speed;
   logic pwm;
   logic busy;

   fan_speed_ctrl #(
      .LEVELS   (LEVELS),
      .DWELL    (DWELL),
      .PWM_BITS (PWM_BITS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .up       (up),
      .down     (down),
      .overtemp (overtemp),
      .speed    (speed),
      .pwm      (pwm),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit u;
      bit d;
      bit o;
      int speed;
      bit busy;
   } vec_t;

   typedef struct {
      int speed;
      bit busy;
      bit pwm;
      int idx;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int n_checks = 0;
   int n_fail   = 0;
   int m_cnt    = 0;
   int m_duty   = 0;
   int m_level  = 0;

   function automatic int duty_of(int lvl);
      return (lvl * PERIOD) / (LEVELS - 1);
   endfunction

   task automatic chk(string name, int idx, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s (vector %0d): got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic reset_model();
      m_cnt   = 0;
      m_duty  = 0;
      m_level = 0;
   endtask

   task automatic add(bit u, bit d, bit o, int s, bit b);
      vec_t v;
      v.u = u; v.d = d; v.o = o; v.speed = s; v.busy = b;
      tbl.push_back(v);
   endtask

   // drive one cycle of inputs, queue expectation, compare after the edge
   task automatic step(bit u, bit d, bit o, int e_speed, bit e_busy, int idx);
      exp_t e;
      up = u;
      down = d;
      overtemp = o;
      if (m_cnt == PERIOD - 1) m_duty = duty_of(m_level);
      m_cnt = (m_cnt + 1) % PERIOD;
      e.speed = e_speed;
      e.busy  = e_busy;
      e.pwm   = (m_cnt < m_duty);
      e.idx   = idx;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("speed", e.idx, int'(speed), e.speed);
      chk("busy",  e.idx, int'(busy),  int'(e.busy));
      chk("pwm",   e.idx, int'(pwm),   int'(e.pwm));
      m_level = e_speed;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      // u d o speed busy
      add(0,1,0, 0,0);
      add(1,0,0, 1,1); add(1,0,0, 1,1); add(1,0,0, 1,1); add(1,0,0, 1,0);
      add(1,0,0, 2,1); add(1,0,0, 2,1); add(1,0,0, 2,1); add(1,0,0, 2,0);
      add(1,0,0, 3,1); add(1,0,0, 3,1); add(1,0,0, 3,1); add(1,0,0, 3,0);
      add(1,0,0, 3,0);
      add(0,1,0, 2,1); add(1,0,0, 2,1); add(1,0,0, 2,1); add(0,0,0, 2,0);
      add(1,0,0, 3,1); add(1,1,0, 0,0); add(0,1,0, 0,0);
      add(1,0,0, 1,1); add(0,0,0, 1,1); add(0,0,0, 1,1); add(0,0,0, 1,0);
      add(0,1,1, 3,0); add(0,1,1, 3,0); add(1,0,1, 3,0);
      add(0,0,0, 3,1); add(0,1,0, 3,1); add(0,1,0, 3,1); add(0,0,0, 3,0);
      add(0,1,0, 2,1); add(0,0,1, 3,0); add(0,0,0, 3,1);
      add(0,0,0, 3,1); add(0,0,0, 3,1); add(0,0,0, 3,0);
      add(0,1,0, 2,1); add(0,0,0, 2,1); add(0,0,0, 2,1); add(0,0,0, 2,0);

      // reset state
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_speed", -1, int'(speed), 0);
      chk("reset_busy",  -1, int'(busy),  0);
      chk("reset_pwm",   -1, int'(pwm),   0);
      @(negedge clk);
      reset = 1'b1;

      foreach (tbl[i]) step(tbl[i].u, tbl[i].d, tbl[i].o, tbl[i].speed, tbl[i].busy, i);

      // level 2 steady: 10 high cycles in any full period
      hi = 0;
      for (int i = 0; i < 48; i++) begin
         step(0, 0, 0, 2, 0, 100 + i);
         if (i >= 32) hi += int'(pwm);
      end
      chk("pwm_highs_level2", 100, hi, 10);

      // level 3: constant high once the new duty is latched
      step(1, 0, 0, 3, 1, 200);
      hi = 0;
      for (int i = 0; i < 47; i++) begin
         step(0, 0, 0, 3, (i < 2) ? 1'b1 : 1'b0, 201 + i);
         if (i >= 31) hi += int'(pwm);
      end
      chk("pwm_highs_level3", 200, hi, 16);

      // reset mid-lockout while pwm is high, no clock edge
      step(0, 1, 0, 2, 1, 300);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_lock_speed", 301, int'(speed), 0);
      chk("rst_lock_busy",  301, int'(busy),  0);
      chk("rst_lock_pwm",   301, int'(pwm),   0);
      reset_model();
      @(negedge clk);
      reset = 1'b1;
      step(1, 0, 0, 1, 1, 302);

      // reset mid-overtemp, held through an edge with overtemp still high
      step(0, 0, 1, 3, 0, 400);
      step(0, 0, 1, 3, 0, 401);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_ovt_speed", 402, int'(speed), 0);
      chk("rst_ovt_busy",  402, int'(busy),  0);
      chk("rst_ovt_pwm",   402, int'(pwm),   0);
      @(posedge clk);
      #1;
      chk("rst_hold_speed", 403, int'(speed), 0);
      reset_model();
      @(negedge clk);
      overtemp = 1'b0;
      reset = 1'b1;
      step(0, 0, 0, 0, 0, 404);
      step(0, 1, 0, 0, 0, 405);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
